// File: rtl/tb_cmd_pkg.sv
// Shared types for the command dispatcher: opcodes, completion status codes,
// FSM states and the channel-count ceiling.
package tb_cmd_pkg;

    localparam int NB_CH_MAX = 16;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_SET = 3'd1,
        OP_WTR = 3'd2,
        OP_WTF = 3'd3,
        OP_CHK = 3'd4,
        OP_WTS = 3'd5
    } opcode_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_TIMEOUT  = 2'd1,
        ST_MISMATCH = 2'd2,
        ST_BADCMD   = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic opcode_known(input logic [2:0] op);
        return op <= 3'(OP_WTS);
    endfunction

endpackage

// File: rtl/cmd_dispatcher_edge_detector.sv
// Per-bit rise/fall detector against a registered copy of the input, which
// is refreshed every cycle regardless of what the dispatcher is doing.
module edge_detector #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;
    assign fall_o = ~sig_i & prev_q;

endmodule

// File: rtl/cmd_dispatcher.sv
// Single-outstanding command engine: set strobes, masked checks, edge waits
// with timeout and fixed-length delays, each ending in one o_done pulse.
//
// state  | meaning
// IDLE   | ready for a command; fields latched on accept
// EXEC   | one cycle: set strobe / compare / decode; bad commands resolve here
// WAIT   | WTR/WTF edge wait with optional timeout, or WTS delay
// DONE   | o_done pulse with o_status; always returns to IDLE
module cmd_dispatcher
    import tb_cmd_pkg::*;
#(
    parameter int NB_CH  = 4,
    parameter int DATA_W = 32,
    parameter int TO_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [2:0]              i_opcode,
    input  logic [3:0]              i_ch,
    input  logic [DATA_W-1:0]       i_data,
    input  logic [DATA_W-1:0]       i_mask,
    input  logic [TO_W-1:0]         i_timeout,
    output logic [NB_CH-1:0]        o_set_en,
    output logic [DATA_W-1:0]       o_set_data,
    input  logic [NB_CH-1:0]        i_wait_sig,
    input  logic [NB_CH*DATA_W-1:0] i_chk_data,
    output logic                    o_done,
    output logic [1:0]              o_status
);

    localparam logic [4:0]      NB_CH_L = 5'((NB_CH > NB_CH_MAX) ? NB_CH_MAX : NB_CH);
    localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

    state_e            state_q, state_d;
    opcode_e           op_q;
    logic [3:0]        ch_q;
    logic [DATA_W-1:0] data_q, mask_q;
    logic [TO_W-1:0]   timeout_q;
    logic              bad_q;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    status_e           status_q, status_d;

    logic              accept;
    logic              bad_d;
    logic [NB_CH-1:0]  rise, fall;
    logic              ch_rise, ch_fall;
    logic [DATA_W-1:0] ch_obs;
    logic [NB_CH-1:0]  ch_onehot;
    logic              edge_hit;
    logic [TO_W-1:0]   wts_last;
    logic              set_active;

    edge_detector #(
        .WIDTH (NB_CH)
    ) u_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (i_wait_sig),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign accept = i_cmd_valid & o_cmd_ready;
    assign bad_d  = !opcode_known(i_opcode) || ({1'b0, i_ch} >= NB_CH_L);

    // Channel select by loop so an out-of-range ch_q never indexes past the buses.
    always_comb begin
        ch_rise   = 1'b0;
        ch_fall   = 1'b0;
        ch_obs    = '0;
        ch_onehot = '0;
        for (int k = 0; k < NB_CH; k++) begin
            if (ch_q == 4'(k)) begin
                ch_rise      = rise[k];
                ch_fall      = fall[k];
                ch_obs       = i_chk_data[k*DATA_W +: DATA_W];
                ch_onehot[k] = 1'b1;
            end
        end
    end

    assign edge_hit = (op_q == OP_WTR) ? ch_rise : ch_fall;
    assign wts_last = (timeout_q == '0) ? '0 : (timeout_q - CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            ch_q      <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            timeout_q <= '0;
            bad_q     <= 1'b0;
            cnt_q     <= '0;
            status_q  <= ST_OK;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            if (accept) begin
                op_q      <= opcode_e'(i_opcode);
                ch_q      <= i_ch;
                data_q    <= i_data;
                mask_q    <= i_mask;
                timeout_q <= i_timeout;
                bad_q     <= bad_d;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bad_q) begin
                    state_d  = S_DONE;
                    status_d = ST_BADCMD;
                end else begin
                    case (op_q)
                        OP_NOP, OP_SET: begin
                            state_d  = S_DONE;
                            status_d = ST_OK;
                        end
                        OP_CHK: begin
                            state_d  = S_DONE;
                            status_d = ((ch_obs & mask_q) == (data_q & mask_q)) ? ST_OK : ST_MISMATCH;
                        end
                        OP_WTR, OP_WTF, OP_WTS: begin
                            state_d = S_WAIT;
                            cnt_d   = '0;
                        end
                        default: begin
                            state_d  = S_DONE;
                            status_d = ST_BADCMD;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                if (op_q == OP_WTS) begin
                    if (cnt_q >= wts_last) begin
                        state_d  = S_DONE;
                        status_d = ST_OK;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (edge_hit) begin
                    // An edge on the last allowed cycle still wins over the timeout.
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end else if ((timeout_q != '0) && (cnt_q == timeout_q - CNT_ONE)) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        set_active  = (state_q == S_EXEC) && (op_q == OP_SET) && !bad_q;
        o_cmd_ready = (state_q == S_IDLE) && !rst;
        o_set_en    = set_active ? ch_onehot : '0;
        o_set_data  = set_active ? data_q : '0;
        o_done      = (state_q == S_DONE);
        o_status    = status_q;
    end

endmodule
